// File: rtl/bram_stream_fifo.sv
// Valid/ready stream FIFO controller for an external true-dual-port BRAM (A writes, B reads),
// with a 2-entry output stage that hides the read latency. Optional: BRAM_STREAM_FIFO_LEVEL_EN.
module bram_stream_fifo #(
  parameter int unsigned DataWidth = 16,
  parameter int unsigned AddrWidth = 9
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 flush_i,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [DataWidth-1:0] s_data_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [DataWidth-1:0] m_data_o,
  output logic [AddrWidth-1:0] addra_o,
  output logic                 ena_o,
  output logic                 wea_o,
  output logic [DataWidth-1:0] dina_o,
  output logic [AddrWidth-1:0] addrb_o,
  output logic                 enb_o,
  output logic                 web_o,
  input  logic [DataWidth-1:0] doutb_i
`ifdef BRAM_STREAM_FIFO_LEVEL_EN
  ,
  output logic [AddrWidth+1:0] level_o
`endif
);

  localparam logic [AddrWidth:0] MemDepth = {1'b1, {AddrWidth{1'b0}}};
  localparam logic [AddrWidth:0] PtrOne   = {{AddrWidth{1'b0}}, 1'b1};

  logic [AddrWidth:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, mem_cnt;
  logic                 rd_pend_q, rd_pend_d;
  logic                 alive_q;
  logic [1:0]           out_cnt_q, out_cnt_d;
  logic [DataWidth-1:0] head_q, head_d, skid_q, skid_d;
  logic                 full, push, pop, rd;
  logic [2:0]           stage_used;

  always_comb begin
    mem_cnt    = wr_ptr_q - rd_ptr_q;
    full       = (mem_cnt == MemDepth);
    // alive_q keeps s_ready_o low while reset is asserted
    s_ready_o  = alive_q & ~full & ~flush_i;
    push       = s_valid_i & s_ready_o;
    m_valid_o  = (out_cnt_q != 2'd0);
    m_data_o   = head_q;
    pop        = m_valid_o & m_ready_i;
    stage_used = {1'b0, out_cnt_q} + {2'b00, rd_pend_q};
    rd         = (mem_cnt != '0) && !flush_i && (stage_used < (3'd2 + {2'b00, pop}));

    ena_o   = push;
    wea_o   = push;
    addra_o = wr_ptr_q[AddrWidth-1:0];
    dina_o  = push ? s_data_i : '0;
    enb_o   = rd;
    addrb_o = rd_ptr_q[AddrWidth-1:0];
    web_o   = 1'b0;
  end

  always_comb begin
    wr_ptr_d  = push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d  = rd ? rd_ptr_q + PtrOne : rd_ptr_q;
    rd_pend_d = rd;
    head_d    = head_q;
    skid_d    = skid_q;
    out_cnt_d = out_cnt_q;

    case (out_cnt_q)
      2'd0: begin
        if (rd_pend_q) begin
          head_d    = doutb_i;
          out_cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (rd_pend_q && pop) begin
          head_d = doutb_i;
        end else if (rd_pend_q) begin
          skid_d    = doutb_i;
          out_cnt_d = 2'd2;
        end else if (pop) begin
          out_cnt_d = 2'd0;
        end
      end
      default: begin
        // A capture while holding two words only happens together with a pop
        if (pop) begin
          head_d = skid_q;
          if (rd_pend_q) skid_d = doutb_i;
          else           out_cnt_d = 2'd1;
        end
      end
    endcase

    if (flush_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      rd_pend_d = 1'b0;
      out_cnt_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      rd_pend_q <= 1'b0;
      out_cnt_q <= 2'd0;
      head_q    <= '0;
      skid_q    <= '0;
      alive_q   <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      rd_pend_q <= rd_pend_d;
      out_cnt_q <= out_cnt_d;
      head_q    <= head_d;
      skid_q    <= skid_d;
      alive_q   <= 1'b1;
    end
  end

`ifdef BRAM_STREAM_FIFO_LEVEL_EN
  always_comb begin
    level_o = {1'b0, mem_cnt} + {{(AddrWidth+1){1'b0}}, rd_pend_q}
            + {{AddrWidth{1'b0}}, out_cnt_q};
  end
`endif

endmodule

// File: tb/tb_bram_stream_fifo.sv
// Scoreboard bench for bram_stream_fifo with a behavioural BRAM and a queue reference model.
module tb_bram_stream_fifo;
  localparam int DW = 16;
  localparam int AW = 4;

  logic          clk_i = 1'b0;
  logic          rst_n_i = 1'b0;
  logic          flush_i = 1'b0;
  logic          s_valid_i = 1'b0;
  logic          m_ready_i = 1'b0;
  logic [DW-1:0] s_data_i = '0;
  logic          s_ready_o, m_valid_o, ena_o, wea_o, enb_o, web_o;
  logic [DW-1:0] m_data_o, dina_o, doutb_i;
  logic [AW-1:0] addra_o, addrb_o;
`ifdef BRAM_STREAM_FIFO_LEVEL_EN
  logic [AW+1:0] level_o;
`endif

  bram_stream_fifo #(.DataWidth(DW), .AddrWidth(AW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .addra_o(addra_o), .ena_o(ena_o), .wea_o(wea_o), .dina_o(dina_o),
    .addrb_o(addrb_o), .enb_o(enb_o), .web_o(web_o), .doutb_i(doutb_i)
`ifdef BRAM_STREAM_FIFO_LEVEL_EN
    , .level_o(level_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  logic [DW-1:0] bram [2**AW];
  always @(posedge clk_i) begin
    if (ena_o && wea_o) bram[addra_o] <= dina_o;
    if (enb_o) doutb_i <= bram[addrb_o];
  end

  int n_chk = 0;
  int n_pass = 0;
  int pops = 0;
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: samples handshakes on the falling edge, ahead of the rising edge that commits them
  always @(negedge clk_i) begin
    if (rst_n_i) begin
`ifdef BRAM_STREAM_FIFO_LEVEL_EN
      chk("level", 32'(level_o), 32'(exp_q.size()));
`endif
      if (m_valid_o && m_ready_i) begin
        pops++;
        if (exp_q.size() == 0) chk("pop_underflow", 32'd1, 32'd0);
        else chk("data", 32'(m_data_o), 32'(exp_q.pop_front()));
      end
      if (s_valid_i && s_ready_o) exp_q.push_back(s_data_i);
      if (flush_i) exp_q.delete();
    end
  end

  always @(negedge rst_n_i) exp_q.delete();

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drain();
    int t = 0;
    m_ready_i = 1'b1;
    s_valid_i = 1'b0;
    while ((exp_q.size() != 0 || m_valid_o) && t < 1000) begin
      step();
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc, p0, stall, gaps, first_v, sent, t;
    bit will, seen;

    // Reset state
    #1;
    chk("rst_s_ready", 32'(s_ready_o), 32'd0);
    chk("rst_m_valid", 32'(m_valid_o), 32'd0);
    chk("rst_m_data", 32'(m_data_o), 32'd0);
    chk("rst_ena_wea", {30'd0, ena_o, wea_o}, 32'd0);
    chk("rst_enb_web", {30'd0, enb_o, web_o}, 32'd0);
    chk("rst_addr", {24'd0, addra_o, addrb_o}, 32'd0);
    chk("rst_dina", 32'(dina_o), 32'd0);
    step(); step();
    rst_n_i = 1'b1;
    step();
    chk("ready_after_rst", 32'(s_ready_o), 32'd1);

    // Single word latency
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 16'h0A5A;
    step();
    s_valid_i = 1'b0;
    chk("lat_c1", 32'(m_valid_o), 32'd0);
    step();
    chk("lat_c2", 32'(m_valid_o), 32'd0);
    step();
    chk("lat_c3_valid", 32'(m_valid_o), 32'd1);
    chk("lat_c3_data", 32'(m_data_o), 32'h0A5A);
    drain();

    // Capacity with consumer stalled
    m_ready_i = 1'b0;
    s_valid_i = 1'b1;
    acc = 0;
    s_data_i = 16'(acc);
    for (int k = 0; k < 40; k++) begin
      will = s_ready_o;
      step();
      if (will) begin
        acc++;
        s_data_i = 16'(acc);
      end
    end
    s_valid_i = 1'b0;
    chk("capacity", 32'(acc), 32'd18);
    chk("full_not_ready", 32'(s_ready_o), 32'd0);
    drain();

    // Continuous streaming 0..999
    m_ready_i = 1'b1;
    p0 = pops; stall = 0; gaps = 0; first_v = -1; seen = 0;
    for (int c = 0; c < 1010; c++) begin
      s_valid_i = (c < 1000);
      s_data_i  = 16'(c);
      if (c < 1000 && !s_ready_o) stall++;
      if (m_valid_o) begin
        if (!seen) first_v = c;
        seen = 1;
      end else if (seen && (pops - p0) < 1000) gaps++;
      step();
    end
    s_valid_i = 1'b0;
    drain();
    chk("stream_stalls", 32'(stall), 32'd0);
    chk("stream_gaps", 32'(gaps), 32'd0);
    chk("stream_first", 32'(first_v), 32'd3);
    chk("stream_count", 32'(pops - p0), 32'd1000);

    // Random handshakes, many pointer wraps
    p0 = pops; sent = 0; t = 0;
    while (sent < 10000 && t < 50000) begin
      s_valid_i = 1'($urandom_range(0, 1));
      s_data_i  = 16'($urandom);
      m_ready_i = 1'($urandom_range(0, 1));
      if (s_valid_i && s_ready_o) sent++;
      step();
      t++;
    end
    s_valid_i = 1'b0;
    drain();
    chk("rand_sent", 32'(sent), 32'd10000);
    chk("rand_count", 32'(pops - p0), 32'd10000);

    // Flush with five words stored and a read in flight
    m_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 16'(16'h100 + i);
      step();
    end
    s_valid_i = 1'b0;
    step(); step(); step(); step();
    m_ready_i = 1'b1;
    step();
    m_ready_i = 1'b0;
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    chk("flush_m_valid", 32'(m_valid_o), 32'd0);
`ifdef BRAM_STREAM_FIFO_LEVEL_EN
    chk("flush_level", 32'(level_o), 32'd0);
`endif
    m_ready_i = 1'b1;
    s_valid_i = 1'b1;
    s_data_i  = 16'h1234;
    step();
    s_valid_i = 1'b0;
    chk("flush_stale_c1", 32'(m_valid_o), 32'd0);
    step();
    chk("flush_stale_c2", 32'(m_valid_o), 32'd0);
    step();
    chk("flush_new_valid", 32'(m_valid_o), 32'd1);
    chk("flush_new_data", 32'(m_data_o), 32'h1234);
    drain();

    // Asynchronous reset mid-burst
    m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      s_valid_i = 1'b1;
      s_data_i  = 16'(16'h200 + i);
      step();
    end
    chk("burst_active", 32'(m_valid_o), 32'd1);
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("arst_m_valid", 32'(m_valid_o), 32'd0);
    chk("arst_s_ready", 32'(s_ready_o), 32'd0);
    chk("arst_ena", 32'(ena_o), 32'd0);
    chk("arst_enb", 32'(enb_o), 32'd0);
    s_valid_i = 1'b0;
    step();
    rst_n_i = 1'b1;
    step();
    s_valid_i = 1'b1;
    s_data_i  = 16'h0BEE;
    step();
    s_valid_i = 1'b0;
    p0 = pops;
    drain();
    chk("post_rst_count", 32'(pops - p0), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
